msk_sbox_layer_sequencer: RTL and testbench

Control and buffering stage that sits directly upstream and downstream of the masked dual S-box unit in the Clyde datapath. It accepts a full masked state (d shares × Nbits) in one handshake and feeds it to the S-box unit one column bundle per cycle. It runs the unit's enable and inverse controls and stalls the unit when randomness is unavailable. It captures each bundle's result after the unit's fixed 3-enabled-cycle latency and returns the reassembled post-S-box state through an output handshake.

---
 rtl/msk_sbox_layer_sequencer.sv | 124 ++++++++++++
 tb/tb_msk_sbox_layer_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/msk_sbox_layer_sequencer.sv
// Feeds a buffered masked state to the dual S-box unit one bundle per enabled cycle and reassembles the results.
// Build option: define SBOX_SEQ_CLEAR_EN to zero buffer/result after each output handshake and gate sb_cols outside RUN.
module msk_sbox_layer_sequencer #(
  parameter int d      = 2,
  parameter int PDSBOX = 0,
  parameter int Nbits  = 128
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           in_inverse,
  input  logic [d*Nbits-1:0]             state_in,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [d*Nbits-1:0]             state_out,
  input  logic                           rnd_valid,
  output logic                           rnd_consume,
  output logic [d*Nbits/(2**PDSBOX)-1:0] sb_cols,
  output logic                           sb_enable,
  output logic                           sb_inverse,
  input  logic [d*Nbits/(2**PDSBOX)-1:0] sb_cols_post
);
  localparam int NB        = 2**PDSBOX;
  localparam int SIZE_BUND = d*Nbits/NB;
  localparam int CW        = $clog2(NB+3);
  localparam logic [CW-1:0] LAST_CNT = CW'(NB+2);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 inv_q, inv_d;
  logic [d*Nbits-1:0]   buf_q, buf_d;
  logic [d*Nbits-1:0]   res_q, res_d;
  logic [SIZE_BUND-1:0] cols_run;

  // Bundle selected by cnt; the three flush slots past the last bundle present zeros.
  always_comb begin
    cols_run = '0;
    for (int k = 0; k < NB; k++) begin
      if (cnt_q == CW'(k)) cols_run = buf_q[k*SIZE_BUND +: SIZE_BUND];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    inv_d   = inv_q;
    buf_d   = buf_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = RUN;
          cnt_d   = '0;
          inv_d   = in_inverse;
          buf_d   = state_in;
        end
      end
      RUN: begin
        if (rnd_valid) begin
          // The unit's output lags its input by three enabled cycles.
          for (int k = 0; k < NB; k++) begin
            if (cnt_q == CW'(k+3)) res_d[k*SIZE_BUND +: SIZE_BUND] = sb_cols_post;
          end
          if (cnt_q == LAST_CNT) state_d = DONE;
          else                   cnt_d   = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
`ifdef SBOX_SEQ_CLEAR_EN
          buf_d = '0;
          res_d = '0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      inv_q   <= 1'b0;
      buf_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      inv_q   <= inv_d;
      buf_q   <= buf_d;
      res_q   <= res_d;
    end
  end

`ifdef SBOX_SEQ_CLEAR_EN
  assign sb_cols = (state_q == RUN) ? cols_run : '0;
`else
  logic [SIZE_BUND-1:0] cols_q, cols_d;

  assign cols_d = (state_q == RUN) ? cols_run : cols_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cols_q <= '0;
    else        cols_q <= cols_d;
  end

  assign sb_cols = cols_d;
`endif

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign sb_enable   = (state_q == RUN) && rnd_valid;
  assign rnd_consume = sb_enable;
  assign sb_inverse  = inv_q;
  assign state_out   = res_q;

endmodule

// File: tb/tb_msk_sbox_layer_sequencer.sv
// Directed bench: two sequencer builds (4 bundles and 1 bundle) driving a behavioural masked S-box unit model.
module tb_msk_sbox_layer_sequencer;
  localparam int W = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid_a = 1'b0, in_valid_b = 1'b0;
  logic         in_inverse = 1'b0, out_ready = 1'b1, rnd_valid = 1'b0;
  logic [W-1:0] state_in = '0;
  logic         sel = 1'b0;

  logic         in_ready_a, out_valid_a, rnd_consume_a, sb_enable_a, sb_inverse_a;
  logic [W-1:0] state_out_a;
  logic [63:0]  sb_cols_a, sb_cols_post_a;
  logic         in_ready_b, out_valid_b, rnd_consume_b, sb_enable_b, sb_inverse_b;
  logic [W-1:0] state_out_b;
  logic [W-1:0] sb_cols_b, sb_cols_post_b;

  int total = 0;
  int bad   = 0;

  msk_sbox_layer_sequencer #(.d(2), .PDSBOX(2), .Nbits(128)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_inverse(in_inverse), .state_in(state_in), .out_valid(out_valid_a),
    .out_ready(out_ready), .state_out(state_out_a), .rnd_valid(rnd_valid),
    .rnd_consume(rnd_consume_a), .sb_cols(sb_cols_a), .sb_enable(sb_enable_a),
    .sb_inverse(sb_inverse_a), .sb_cols_post(sb_cols_post_a));

  msk_sbox_layer_sequencer #(.d(2), .PDSBOX(0), .Nbits(128)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_inverse(in_inverse), .state_in(state_in), .out_valid(out_valid_b),
    .out_ready(out_ready), .state_out(state_out_b), .rnd_valid(rnd_valid),
    .rnd_consume(rnd_consume_b), .sb_cols(sb_cols_b), .sb_enable(sb_enable_b),
    .sb_inverse(sb_inverse_b), .sb_cols_post(sb_cols_post_b));

  wire         ir    = sel ? in_ready_b    : in_ready_a;
  wire         ov    = sel ? out_valid_b   : out_valid_a;
  wire         rc    = sel ? rnd_consume_b : rnd_consume_a;
  wire         sinv  = sel ? sb_inverse_b  : sb_inverse_a;
  wire [W-1:0] sout  = sel ? state_out_b   : state_out_a;
  wire [W-1:0] scols = sel ? sb_cols_b     : {192'b0, sb_cols_a};

  function automatic logic [3:0] sbf(input logic [3:0] x);
    case (x)
      4'h0: return 4'h0;  4'h1: return 4'h8;  4'h2: return 4'h1;  4'h3: return 4'hF;
      4'h4: return 4'h2;  4'h5: return 4'hA;  4'h6: return 4'h7;  4'h7: return 4'h9;
      4'h8: return 4'h4;  4'h9: return 4'hD;  4'hA: return 4'h5;  4'hB: return 4'h6;
      4'hC: return 4'hE;  4'hD: return 4'h3;  4'hE: return 4'hB;  default: return 4'hC;
    endcase
  endfunction

  function automatic logic [3:0] sbi(input logic [3:0] y);
    for (int j = 0; j < 16; j++) if (sbf(4'(j)) == y) return 4'(j);
    return 4'h0;
  endfunction

  // Unit model: bundle = {share1, share0}, each half bits; output re-masked with m.
  function automatic logic [W-1:0] unit_f(input logic [W-1:0] b, input int half,
                                          input logic inv, input logic [127:0] m);
    logic [W-1:0] r = '0;
    logic [3:0]   x;
    for (int i = 0; i < half/4; i++) begin
      x = b[4*i +: 4] ^ b[half+4*i +: 4];
      x = inv ? sbi(x) : sbf(x);
      r[4*i +: 4]      = m[4*i +: 4];
      r[half+4*i +: 4] = x ^ m[4*i +: 4];
    end
    return r;
  endfunction

  function automatic logic [127:0] recomb(input logic [W-1:0] st, input int nb);
    int half = 128/nb;
    logic [127:0] r = '0;
    for (int k = 0; k < nb; k++)
      for (int i = 0; i < half; i++)
        r[k*half+i] = st[k*2*half+i] ^ st[k*2*half+half+i];
    return r;
  endfunction

  function automatic logic [W-1:0] exp_res(input logic [W-1:0] st, input logic inv, input int nb);
    logic [127:0] x = recomb(st, nb);
    logic [127:0] r = '0;
    for (int i = 0; i < 32; i++) r[4*i +: 4] = inv ? sbi(x[4*i +: 4]) : sbf(x[4*i +: 4]);
    return {128'b0, r};
  endfunction

  function automatic logic [W-1:0] rand256();
    logic [W-1:0] r = '0;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  logic [W-1:0] p0a, p1a, p2a, p0b, p1b, p2b;
  always @(posedge clk) begin
    if (sb_enable_a) begin
      p0a <= unit_f({192'b0, sb_cols_a}, 32, sb_inverse_a, {$urandom, $urandom, $urandom, $urandom});
      p1a <= p0a;
      p2a <= p1a;
    end
    if (sb_enable_b) begin
      p0b <= unit_f(sb_cols_b, 128, sb_inverse_b, {$urandom, $urandom, $urandom, $urandom});
      p1b <= p0b;
      p2b <= p1b;
    end
  end
  assign sb_cols_post_a = p2a[63:0];
  assign sb_cols_post_b = p2b;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Offers st, then walks cycle 1.. after the accept until out_valid (cycle number returned in cyc).
  task automatic run_layer(input logic inv, input bit stall, input logic [W-1:0] st,
                           output int cyc, output int cons, output logic [W-1:0] c_first,
                           output logic [W-1:0] c_flush, output bit inv_ok);
    int nb = sel ? 1 : 4;
    cyc = -1; cons = 0; inv_ok = 1'b1; c_first = '0; c_flush = '1;
    state_in = st;
    in_inverse = inv;
    if (sel) in_valid_b = 1'b1; else in_valid_a = 1'b1;
    @(posedge clk); #1;
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    in_inverse = ~inv;
    for (int n = 1; n <= 60; n++) begin
      rnd_valid = stall ? (n % 2 == 0) : 1'b1;
      #1;
      if (rc) cons++;
      if (sinv !== inv) inv_ok = 1'b0;
      if (n == 1) c_first = scols;
      if (n == nb + 1) c_flush = scols;
      if (ov) begin
        cyc = n;
        break;
      end
      @(posedge clk); #1;
    end
    rnd_valid = 1'b1;
  endtask

  initial begin
    int           cyc, cons;
    logic [W-1:0] c_first, c_flush, st1, st2, st3, st4, hold;
    bit           inv_ok, ov_ok, stable_ok, ir_quiet;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", W'(in_ready_a), W'(1));
    chk("rst_out_valid", W'(out_valid_a), W'(0));
    chk("rst_sb_enable", W'(sb_enable_a), W'(0));
    chk("rst_rnd_consume", W'(rnd_consume_a), W'(0));
    chk("rst_sb_inverse", W'(sb_inverse_a), W'(0));
    chk("rst_sb_cols", W'(sb_cols_a), W'(0));
    chk("rst_state_out", state_out_a, W'(0));
    chk("rst_b_in_ready", W'(in_ready_b), W'(1));
    chk("rst_b_out_valid", W'(out_valid_b), W'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Forward layer, no stalls: out_valid in cycle 8, 7 enabled cycles.
    st1 = rand256();
    run_layer(1'b0, 1'b0, st1, cyc, cons, c_first, c_flush, inv_ok);
    chk("fwd_cycle", W'(cyc), W'(8));
    chk("fwd_consume", W'(cons), W'(7));
    chk("fwd_result", {128'b0, recomb(sout, 4)}, exp_res(st1, 1'b0, 4));
    chk("fwd_cols_bundle0", c_first, {192'b0, st1[63:0]});
    chk("fwd_cols_flush", c_flush, W'(0));
    chk("fwd_inverse_held", W'(inv_ok), W'(1));
    @(posedge clk); #1;
    chk("fwd_back_idle", W'(ir), W'(1));
    chk("fwd_out_valid_low", W'(ov), W'(0));

    // Inverse layer.
    st2 = rand256();
    run_layer(1'b1, 1'b0, st2, cyc, cons, c_first, c_flush, inv_ok);
    chk("inv_cycle", W'(cyc), W'(8));
    chk("inv_result", {128'b0, recomb(sout, 4)}, exp_res(st2, 1'b1, 4));
    chk("inv_inverse_held", W'(inv_ok), W'(1));
    @(posedge clk); #1;

    // Randomness toggling 0,1,0,1...: seven stall cycles added.
    run_layer(1'b0, 1'b1, st1, cyc, cons, c_first, c_flush, inv_ok);
    chk("stall_cycle", W'(cyc), W'(15));
    chk("stall_consume", W'(cons), W'(7));
    chk("stall_result", {128'b0, recomb(sout, 4)}, exp_res(st1, 1'b0, 4));
    @(posedge clk); #1;

    // Consumer back-pressure for 20 cycles; in_valid offered throughout and must be ignored.
    out_ready = 1'b0;
    st3 = rand256();
    run_layer(1'b0, 1'b0, st3, cyc, cons, c_first, c_flush, inv_ok);
    chk("bp_cycle", W'(cyc), W'(8));
    chk("bp_result", {128'b0, recomb(sout, 4)}, exp_res(st3, 1'b0, 4));
    hold = sout;
    in_valid_a = 1'b1;
    state_in = rand256();
    ov_ok = 1'b1; stable_ok = 1'b1; ir_quiet = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (ov !== 1'b1) ov_ok = 1'b0;
      if (sout !== hold) stable_ok = 1'b0;
      if (ir !== 1'b0) ir_quiet = 1'b0;
    end
    chk("bp_out_valid_held", W'(ov_ok), W'(1));
    chk("bp_state_out_stable", W'(stable_ok), W'(1));
    chk("bp_in_ready_low", W'(ir_quiet), W'(1));
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_idle_after_hs", W'(ir), W'(1));
    chk("bp_out_valid_low", W'(ov), W'(0));
`ifdef SBOX_SEQ_CLEAR_EN
    chk("bp_state_out_cleared", sout, W'(0));
`else
    chk("bp_state_out_retained", sout, hold);
`endif
    in_valid_a = 1'b0;
    @(posedge clk); #1;

    // Reset pulse while RUN is at cnt=2, checked before any further clock edge.
    st4 = rand256();
    state_in = st4;
    in_inverse = 1'b1;
    rnd_valid = 1'b1;
    in_valid_a = 1'b1;
    @(posedge clk); #1;
    in_valid_a = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk("mid_run_enabled", W'(sb_enable_a), W'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", W'(in_ready_a), W'(1));
    chk("arst_out_valid", W'(out_valid_a), W'(0));
    chk("arst_sb_enable", W'(sb_enable_a), W'(0));
    chk("arst_rnd_consume", W'(rnd_consume_a), W'(0));
    chk("arst_sb_inverse", W'(sb_inverse_a), W'(0));
    chk("arst_sb_cols", W'(sb_cols_a), W'(0));
    chk("arst_state_out", state_out_a, W'(0));
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    run_layer(1'b0, 1'b0, st4, cyc, cons, c_first, c_flush, inv_ok);
    chk("post_rst_cycle", W'(cyc), W'(8));
    chk("post_rst_result", {128'b0, recomb(sout, 4)}, exp_res(st4, 1'b0, 4));
    @(posedge clk); #1;

    // Single-bundle build: RUN lasts 4 cycles.
    sel = 1'b1;
    st1 = rand256();
    run_layer(1'b0, 1'b0, st1, cyc, cons, c_first, c_flush, inv_ok);
    chk("nb1_cycle", W'(cyc), W'(5));
    chk("nb1_consume", W'(cons), W'(4));
    chk("nb1_result", {128'b0, recomb(sout, 1)}, exp_res(st1, 1'b0, 1));
    chk("nb1_cols_bundle0", c_first, st1);
    chk("nb1_cols_flush", c_flush, W'(0));
    hold = sout;
    @(posedge clk); #1;
    chk("nb1_back_idle", W'(ir), W'(1));
    chk("nb1_cols_idle", scols, W'(0));
`ifdef SBOX_SEQ_CLEAR_EN
    chk("nb1_state_out_cleared", sout, W'(0));
`else
    chk("nb1_state_out_retained", sout, hold);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
